max_stream_gen: RTL and testbench

//  Initiator side of the find_max streaming protocol: on request, drives a burst of LEN

---
 rtl/max_stream_gen.sv | 142 ++++++++++++++
 tb/tb_max_stream_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/max_stream_gen.sv
// ---------------------------------------------------------------------------
// max_stream_gen
//   Initiator side of the find_max streaming protocol. On an accepted request
//   it emits a burst of len pseudo-random samples (from a 16-bit Galois LFSR),
//   framed by start. It tracks the running maximum of what it sent, then
//   waits for the sink's done_in strobe and compares the returned max_in with
//   that maximum. If the sink stays silent it gives up after TIMEOUT cycles.
//   Intended as an on-chip self-test source for find_max.
//
// Ports
//   clk          clock, all state on posedge
//   rst_n        asynchronous reset, active HIGH despite the name
//   go / len     burst request and burst length, sampled in IDLE only
//   load_seed    IDLE only: reload the LFSR from seed (0 -> LFSR_SEED)
//   seed         seed value for load_seed
//   start        frame to the sink, high for exactly len cycles
//   data_out     current sample while start=1, otherwise 0
//   done_in      sink result strobe (honoured in WAIT only)
//   max_in       sink's maximum, sampled together with done_in
//   busy         high in SEND / WAIT / REPORT
//   result_valid one-cycle verdict pulse
//   pass         sticky: max_in matched exp_max; cleared on accepted go
//   timeout      sticky: sink never answered; cleared on accepted go
//   exp_max      running unsigned max of emitted samples
//
// Handshake: there is no back-pressure on the sample stream. Every cycle
// with start=1 transfers one data_out sample. After start falls the sink
// answers with a single-cycle done_in, with max_in valid in that same cycle.
// The FSM state is held in state_q, which is readable for checkers.
// ---------------------------------------------------------------------------
module max_stream_gen #(
  parameter int          W         = 8,
  parameter int          LEN_W     = 16,
  parameter int          TIMEOUT   = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [LEN_W-1:0] len,
  input  logic             load_seed,
  input  logic [15:0]      seed,
  output logic             start,
  output logic [W-1:0]     data_out,
  input  logic             done_in,
  input  logic [W-1:0]     max_in,
  output logic             busy,
  output logic             result_valid,
  output logic             pass,
  output logic             timeout,
  output logic [W-1:0]     exp_max
);

  localparam int             WC_W      = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(TIMEOUT);
  // Right-shift Galois feedback mask for x^16+x^14+x^13+x^11+1.
  localparam logic [15:0]    LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [WC_W-1:0]  wcnt_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_next;
  logic [W-1:0]     sample;
  logic             go_ok;

  assign go_ok     = go && (len != '0);
  assign sample    = lfsr_q[W-1:0];
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

  // Outputs are decoded from the registered state, so an asynchronous reset
  // drops start and data_out in the same cycle.
  assign start        = (state_q == S_SEND);
  assign data_out     = start ? sample : '0;
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_REPORT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go_ok) state_d = S_SEND;
      S_SEND:   if (cnt_q == LEN_W'(1)) state_d = S_WAIT;
      S_WAIT:   if (done_in || (wcnt_q == TIMEOUT_V)) state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      exp_max <= '0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          // The seed load happens in the go cycle too, so a combined
          // load_seed+go burst starts from the new seed.
          if (load_seed) lfsr_q <= (seed == '0) ? LFSR_SEED : seed;
          if (go_ok) begin
            cnt_q   <= len;
            exp_max <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        S_SEND: begin
          lfsr_q <= lfsr_next;
          if (sample > exp_max) exp_max <= sample;
          cnt_q  <= cnt_q - LEN_W'(1);
          // wcnt holds the 1-based index of the current WAIT cycle.
          wcnt_q <= WC_W'(1);
        end
        S_WAIT: begin
          // done_in takes priority, including on the final TIMEOUT cycle.
          if (done_in) begin
            pass <= (max_in == exp_max);
          end else if (wcnt_q == TIMEOUT_V) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + WC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max_stream_gen.sv
module tb_max_stream_gen;

  localparam int          W       = 8;
  localparam int          LEN_W   = 16;
  localparam int          TIMEOUT = 64;
  localparam logic [15:0] SEED    = 16'hACE1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             go;
  logic [LEN_W-1:0] len;
  logic             load_seed;
  logic [15:0]      seed;
  logic             start;
  logic [W-1:0]     data_out;
  logic             done_in;
  logic [W-1:0]     max_in;
  logic             busy;
  logic             result_valid;
  logic             pass;
  logic             timeout;
  logic [W-1:0]     exp_max;

  always #5 clk = ~clk;

  max_stream_gen #(.W(W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .len(len), .load_seed(load_seed),
    .seed(seed), .start(start), .data_out(data_out), .done_in(done_in),
    .max_in(max_in), .busy(busy), .result_valid(result_valid), .pass(pass),
    .timeout(timeout), .exp_max(exp_max)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // LFSR built from the polynomial's tap exponents (right-shifting Galois form).
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int taps[4] = '{16, 14, 13, 11};
    logic [15:0] mask = '0;
    foreach (taps[i]) mask[taps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  // mode: 0 sink echoes true max, 1 sink returns max-1, 2 sink silent
  task automatic do_burst(input logic ld, input logic [15:0] sd, input int n,
                          input int mode, input int delay, input bit mid_go,
                          input bit noise, input bit exp_pass, input bit exp_to);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mmax;
    logic [W-1:0] ret;
    int k;
    load_seed = ld; seed = sd; go = 1'b1; len = LEN_W'(n);
    if (ld) m_lfsr = (sd == 16'h0) ? SEED : sd;
    mmax = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_lfsr[W-1:0]);
      m_lfsr = lfsr_step(m_lfsr);
    end
    foreach (exp_q[i]) if (exp_q[i] > mmax) mmax = exp_q[i];
    @(negedge clk);
    go = 1'b0; load_seed = 1'b0; len = LEN_W'($urandom); seed = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      chk("start_hi", start, 1);
      chk("busy_send", busy, 1);
      chk("data", data_out, exp_q[i]);
      done_in   = noise && (i < n - 1);
      max_in    = W'($urandom);
      go        = mid_go && (i == 1);
      load_seed = mid_go && (i == 1);
      len       = LEN_W'(5);
      @(negedge clk);
    end
    done_in = 1'b0; go = 1'b0; load_seed = 1'b0;
    chk("start_lo", start, 0);
    chk("data_idle", data_out, 0);
    chk("exp_max", exp_max, mmax);
    chk("busy_wait", busy, 1);
    if (mode == 2) begin
      k = 1;
      while (!result_valid && k < TIMEOUT + 20) begin
        @(negedge clk);
        k++;
      end
      chk("to_latency", k, TIMEOUT + 1);
    end else begin
      ret = (mode == 0) ? mmax : mmax - W'(1);
      repeat (delay) @(negedge clk);
      chk("rv_before_done", result_valid, 0);
      done_in = 1'b1; max_in = ret;
      @(negedge clk);
      done_in = 1'b0;
    end
    chk("rv_pulse", result_valid, 1);
    chk("pass", pass, exp_pass);
    chk("timeout", timeout, exp_to);
    chk("busy_report", busy, 1);
    @(negedge clk);
    chk("rv_single", result_valid, 0);
    chk("busy_idle", busy, 0);
    chk("pass_sticky", pass, exp_pass);
    chk("timeout_sticky", timeout, exp_to);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ld;
    logic [15:0] sd;
    int          n;
    int          mode;
    int          delay;
    bit          mid_go;
    bit          noise;
    bit          exp_pass;
    bit          exp_to;
  } vec_t;

  vec_t tab[6];

  initial begin
    tab[0] = '{1'b1, 16'h0001, 3,  0, 0,  1'b0, 1'b0, 1'b1, 1'b0}; // seeded, echo
    tab[1] = '{1'b0, 16'h0000, 10, 1, 2,  1'b0, 1'b1, 1'b0, 1'b0}; // wrong max
    tab[2] = '{1'b0, 16'h0000, 4,  2, 0,  1'b0, 1'b0, 1'b0, 1'b1}; // silent sink
    tab[3] = '{1'b1, 16'h0000, 8,  0, 1,  1'b1, 1'b0, 1'b1, 1'b0}; // zero seed, go mid-send
    tab[4] = '{1'b0, 16'h0000, 1,  0, 63, 1'b0, 1'b0, 1'b1, 1'b0}; // done on last wait cycle
    tab[5] = '{1'b1, 16'hFFFF, 2,  1, 5,  1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b1; go = 1'b0; len = '0; load_seed = 1'b0; seed = '0;
    done_in = 1'b0; max_in = '0;
    m_lfsr = SEED;
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_exp_max", exp_max, 0);
    rst_n = 1'b0;
    @(negedge clk);

    foreach (tab[i])
      do_burst(tab[i].ld, tab[i].sd, tab[i].n, tab[i].mode, tab[i].delay,
               tab[i].mid_go, tab[i].noise, tab[i].exp_pass, tab[i].exp_to);

    // go with len=0 is ignored and leaves sticky flags alone
    go = 1'b1; len = '0;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("len0_busy", busy, 0);
      chk("len0_start", start, 0);
      chk("len0_rv", result_valid, 0);
      chk("len0_pass", pass, tab[5].exp_pass);
      @(negedge clk);
    end
    do_burst(1'b0, 16'h0, 1, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset on the second SEND cycle of a long burst
    go = 1'b1; len = LEN_W'(100);
    @(negedge clk);
    go = 1'b0;
    chk("t5_send1", start, 1);
    chk("t5_data1", data_out, m_lfsr[W-1:0]);
    @(negedge clk);
    chk("t5_send2", start, 1);
    rst_n = 1'b1;
    #1;
    chk("t5_start", start, 0);
    chk("t5_data", data_out, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rv", result_valid, 0);
    chk("t5_pass", pass, 0);
    chk("t5_timeout", timeout, 0);
    chk("t5_exp_max", exp_max, 0);
    m_lfsr = SEED;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    do_burst(1'b0, 16'h0, 3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized bursts
    for (int r = 0; r < 25; r++) begin
      int mode;
      mode = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1));
      do_burst(1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(1, 40)),
               mode, int'($urandom_range(0, TIMEOUT - 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               mode == 0, mode == 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
